// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing, valid/ready offer, prioritised redirects.
// Optional wrong-path epoch counter enabled by defining PCGEN_EPOCH_EN.
module pc_gen #(
    parameter int          WIDTH    = 64,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          STEP     = 4,
    parameter int          NREDIR   = 3,
    parameter int          EPOCH_W  = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    output logic                           o_pc_valid,
    output logic [WIDTH-1:0]               o_pc,
    input  logic                           i_pc_ready,
    output logic                           o_pc_misaligned,
    input  logic [NREDIR-1:0]              i_redirect_valid,
    input  logic [NREDIR-1:0][WIDTH-1:0]   i_redirect_pc,
    input  logic                           i_halt,
    output logic [EPOCH_W-1:0]             o_epoch
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_redir_pc;
    logic             w_redir_any;

    // Scan from the highest index down so the lowest set channel wins.
    always_comb begin
        w_redir_any = |i_redirect_valid;
        w_redir_pc  = '0;
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (i_redirect_valid[i]) begin
                w_redir_pc = i_redirect_pc[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
                if (w_redir_any) begin
                    w_pc_nxt = w_redir_pc;
                end
            end
            S_RUN: begin
                if (w_redir_any) begin
                    w_pc_nxt = w_redir_pc;
                end else if (i_pc_ready) begin
                    w_pc_nxt = r_pc + STEP_W;
                end
                if (i_halt) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (w_redir_any) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = i_halt ? S_HALT : S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_BOOT;
            r_pc    <= RST_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_valid      = (r_state == S_RUN);
    assign o_pc_misaligned = o_pc_valid && (r_pc[1:0] != 2'b00);

`ifdef PCGEN_EPOCH_EN
    logic [EPOCH_W-1:0] r_epoch;

    // Every accepted redirect opens a new epoch, whatever the state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_epoch <= '0;
        end else if (w_redir_any) begin
            r_epoch <= r_epoch + EPOCH_W'(1);
        end
    end

    assign o_epoch = r_epoch;
`else
    assign o_epoch = '0;
`endif

endmodule
